// File: rtl/cfg_mgmt_cc_completion_gen.sv
// Type 1 config completion generator: tracks a CQ config request through cfg_mgmt and returns one CC beat.
// Optional cfg_mgmt wait timeout (CRS completion) is enabled by defining CFG_CPL_TIMEOUT_EN.
module cfg_mgmt_cc_completion_gen #(
    parameter int DSP_IF_WIDTH       = 512,
    parameter int DSP_TKEEP_WIDTH    = 16,
    parameter int DSP_CQ_TUSER_WIDTH = 231,
    parameter int DSP_CC_TUSER_WIDTH = 81,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                          user_clk,
    input  logic                          user_reset,
    input  logic [DSP_IF_WIDTH-1:0]       dsp_m_axis_cq_tdata,
    input  logic                          dsp_m_axis_cq_tvalid,
    input  logic [DSP_CQ_TUSER_WIDTH-1:0] dsp_m_axis_cq_tuser,
    output logic                          cq_cfg_tready,
    input  logic [1:0]                    select,
    input  logic [3:0]                    req_type,
    input  logic [31:0]                   cfg_mgmt_read_data,
    input  logic                          cfg_mgmt_read_write_done,
    output logic [DSP_IF_WIDTH-1:0]       dsp_s_axis_cc_tdata,
    output logic [DSP_TKEEP_WIDTH-1:0]    dsp_s_axis_cc_tkeep,
    output logic                          dsp_s_axis_cc_tlast,
    output logic [DSP_CC_TUSER_WIDTH-1:0] dsp_s_axis_cc_tuser,
    output logic                          dsp_s_axis_cc_tvalid,
    input  logic                          dsp_s_axis_cc_tready,
    output logic                          cfg_cpl_busy
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_DONE = 2'd1;
    localparam logic [1:0] SEND_CPL  = 2'd2;

    logic [1:0]  state;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic [2:0]  status;
    logic        is_write;
    logic        has_data;
    logic [31:0] rdata;
    logic        cfg_hit;
    logic        fn_zero;
    logic        expire;
    logic        cc_valid;
    logic [127:0] desc;
    logic        unused_inputs;

    assign cfg_hit = dsp_m_axis_cq_tvalid && (select == 2'b01) && (req_type[3:2] == 2'b10);
    assign fn_zero = (dsp_m_axis_cq_tdata[111:104] == 8'd0);
    assign unused_inputs = ^{dsp_m_axis_cq_tdata, dsp_m_axis_cq_tuser, req_type[0]};

`ifdef CFG_CPL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_cnt;

    // Held at zero outside WAIT_DONE, so it always starts from zero on entry.
    always_ff @(posedge user_clk) begin
        if (user_reset || state != WAIT_DONE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign expire = (state == WAIT_DONE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign expire = 1'b0;
`endif

    assign cq_cfg_tready = ((state == IDLE) && cfg_hit && !fn_zero) ||
                           ((state == WAIT_DONE) && (cfg_mgmt_read_write_done || expire));

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state    <= IDLE;
            req_id   <= '0;
            tag      <= '0;
            tc       <= '0;
            attr     <= '0;
            status   <= '0;
            is_write <= 1'b0;
            has_data <= 1'b0;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_hit) begin
                        req_id   <= dsp_m_axis_cq_tdata[95:80];
                        tag      <= dsp_m_axis_cq_tdata[103:96];
                        tc       <= dsp_m_axis_cq_tdata[123:121];
                        attr     <= dsp_m_axis_cq_tdata[126:124];
                        is_write <= req_type[1];
                        has_data <= 1'b0;
                        rdata    <= '0;
                        if (fn_zero) begin
                            status <= 3'b000;
                            state  <= WAIT_DONE;
                        end else begin
                            status <= 3'b001;
                            state  <= SEND_CPL;
                        end
                    end
                end
                WAIT_DONE: begin
                    // done takes priority over a coincident timeout
                    if (cfg_mgmt_read_write_done) begin
                        status   <= 3'b000;
                        has_data <= !is_write;
                        rdata    <= is_write ? 32'd0 : cfg_mgmt_read_data;
                        state    <= SEND_CPL;
                    end else if (expire) begin
                        status   <= 3'b010;
                        has_data <= 1'b0;
                        state    <= SEND_CPL;
                    end
                end
                SEND_CPL: begin
                    if (dsp_s_axis_cc_tready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cc_valid = (state == SEND_CPL);

    always_comb begin
        desc          = '0;
        desc[28:16]   = 13'd4;
        desc[42:32]   = {10'd0, has_data};
        desc[45:43]   = status;
        desc[63:48]   = req_id;
        desc[71:64]   = tag;
        desc[91:89]   = tc;
        desc[94:92]   = attr;
        if (has_data) begin
            desc[127:96] = rdata;
        end
    end

    // Beat fields are forced to zero whenever no completion is being offered.
    always_comb begin
        dsp_s_axis_cc_tdata = '0;
        dsp_s_axis_cc_tkeep = '0;
        dsp_s_axis_cc_tuser = '0;
        if (cc_valid) begin
            dsp_s_axis_cc_tdata[127:0] = desc;
            dsp_s_axis_cc_tkeep[3:0]   = has_data ? 4'hF : 4'h7;
            dsp_s_axis_cc_tuser[1:0]   = 2'b01;
            dsp_s_axis_cc_tuser[7:6]   = 2'b01;
            dsp_s_axis_cc_tuser[11:8]  = has_data ? 4'd3 : 4'd2;
        end
    end

    assign dsp_s_axis_cc_tvalid = cc_valid;
    assign dsp_s_axis_cc_tlast  = cc_valid;
    assign cfg_cpl_busy         = (state != IDLE);

endmodule

// File: tb/tb_cfg_mgmt_cc_completion_gen.sv
// Directed self-checking bench for cfg_mgmt_cc_completion_gen (timeout cases run when CFG_CPL_TIMEOUT_EN is defined).
module tb_cfg_mgmt_cc_completion_gen;

    localparam int W  = 512;
    localparam int KW = 16;
    localparam int QU = 231;
    localparam int CU = 81;

    logic          user_clk = 1'b0;
    logic          user_reset;
    logic [W-1:0]  cq_tdata;
    logic          cq_tvalid;
    logic [QU-1:0] cq_tuser;
    logic          cq_cfg_tready;
    logic [1:0]    select;
    logic [3:0]    req_type;
    logic [31:0]   read_data;
    logic          done;
    logic [W-1:0]  cc_tdata;
    logic [KW-1:0] cc_tkeep;
    logic          cc_tlast;
    logic [CU-1:0] cc_tuser;
    logic          cc_tvalid;
    logic          cc_tready;
    logic          busy;

    int n_checks = 0;
    int n_fails  = 0;
    int pops     = 0;

    cfg_mgmt_cc_completion_gen #(
        .DSP_IF_WIDTH(W), .DSP_TKEEP_WIDTH(KW), .DSP_CQ_TUSER_WIDTH(QU),
        .DSP_CC_TUSER_WIDTH(CU), .TIMEOUT_CYCLES(16)
    ) dut (
        .user_clk(user_clk), .user_reset(user_reset),
        .dsp_m_axis_cq_tdata(cq_tdata), .dsp_m_axis_cq_tvalid(cq_tvalid),
        .dsp_m_axis_cq_tuser(cq_tuser), .cq_cfg_tready(cq_cfg_tready),
        .select(select), .req_type(req_type),
        .cfg_mgmt_read_data(read_data), .cfg_mgmt_read_write_done(done),
        .dsp_s_axis_cc_tdata(cc_tdata), .dsp_s_axis_cc_tkeep(cc_tkeep),
        .dsp_s_axis_cc_tlast(cc_tlast), .dsp_s_axis_cc_tuser(cc_tuser),
        .dsp_s_axis_cc_tvalid(cc_tvalid), .dsp_s_axis_cc_tready(cc_tready),
        .cfg_cpl_busy(busy)
    );

    always #5 user_clk = ~user_clk;

    always @(posedge user_clk) begin
        if (cq_cfg_tready && cq_tvalid && !user_reset) pops <= pops + 1;
    end

    task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    function automatic logic [W-1:0] cq_beat(input logic [15:0] rid, input logic [7:0] tg,
                                             input logic [7:0] fn, input logic [2:0] tcl,
                                             input logic [2:0] at);
        logic [W-1:0] d;
        d = '0;
        d[63:0]    = 64'h0000_0000_0000_1A2C;
        d[95:80]   = rid;
        d[103:96]  = tg;
        d[111:104] = fn;
        d[123:121] = tcl;
        d[126:124] = at;
        d[511:500] = 12'hABC;
        return d;
    endfunction

    // wait_n idle WAIT_DONE cycles, then one cycle with done=give_done where a pop is required.
    task automatic do_req(input string nm, input logic [15:0] rid, input logic [7:0] tg,
                          input logic [7:0] fn, input logic wr, input logic [2:0] tcl,
                          input logic [2:0] at, input int wait_n, input logic give_done,
                          input logic [31:0] rd, input logic [127:0] exp_desc,
                          input logic [15:0] exp_keep, input logic [11:0] exp_user, input int hold_n);
        int p0;
        p0        = pops;
        cq_tdata  = cq_beat(rid, tg, fn, tcl, at);
        cq_tvalid = 1'b1;
        select    = 2'b01;
        req_type  = wr ? 4'b1010 : 4'b1000;
        #1;
        if (fn != 8'd0) begin
            chk({nm, "_ur_pop"}, W'(cq_cfg_tready), W'(1));
            tick();
            cq_tvalid = 1'b0;
        end else begin
            chk({nm, "_no_early_pop"}, W'(cq_cfg_tready), W'(0));
            tick();
            chk({nm, "_busy_wait"}, W'(busy), W'(1));
            for (int i = 0; i < wait_n; i++) begin
                chk({nm, "_wait_ready"}, W'(cq_cfg_tready), W'(0));
                chk({nm, "_wait_tvalid"}, W'(cc_tvalid), W'(0));
                tick();
            end
            done      = give_done;
            read_data = rd;
            #1;
            chk({nm, "_done_pop"}, W'(cq_cfg_tready), W'(1));
            tick();
            done      = 1'b0;
            read_data = 32'h0;
            cq_tvalid = 1'b0;
        end
        chk({nm, "_tvalid"}, W'(cc_tvalid), W'(1));
        chk({nm, "_tdata"}, cc_tdata, W'(exp_desc));
        chk({nm, "_tkeep"}, W'(cc_tkeep), W'(exp_keep));
        chk({nm, "_tuser"}, W'(cc_tuser), W'(exp_user));
        chk({nm, "_tlast"}, W'(cc_tlast), W'(1));
        for (int i = 0; i < hold_n; i++) begin
            cq_tdata  = cq_beat(16'h5555, 8'h66, 8'h05, 3'd0, 3'd0);
            cq_tvalid = 1'b1;
            req_type  = 4'b1000;
            #1;
            chk({nm, "_hold_no_pop"}, W'(cq_cfg_tready), W'(0));
            tick();
            chk({nm, "_hold_tdata"}, cc_tdata, W'(exp_desc));
            chk({nm, "_hold_tvalid"}, W'(cc_tvalid), W'(1));
        end
        cq_tvalid = 1'b0;
        cc_tready = 1'b1;
        tick();
        cc_tready = 1'b0;
        chk({nm, "_tvalid_drop"}, W'(cc_tvalid), W'(0));
        chk({nm, "_idle"}, W'(busy), W'(0));
        chk({nm, "_pop_count"}, W'(pops - p0), W'(1));
    endtask

    initial begin
        user_reset = 1'b1;
        cq_tdata   = '0;
        cq_tvalid  = 1'b0;
        cq_tuser   = '0;
        select     = 2'b00;
        req_type   = 4'b0000;
        read_data  = 32'h0;
        done       = 1'b0;
        cc_tready  = 1'b0;
        tick();
        tick();
        chk("rst_tvalid", W'(cc_tvalid), W'(0));
        chk("rst_tdata", cc_tdata, W'(0));
        chk("rst_tkeep", W'(cc_tkeep), W'(0));
        chk("rst_tuser", W'(cc_tuser), W'(0));
        chk("rst_tlast", W'(cc_tlast), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_ready", W'(cq_cfg_tready), W'(0));
        user_reset = 1'b0;
        tick();

        do_req("rd_fn0", 16'h0100, 8'h2A, 8'h00, 1'b0, 3'd0, 3'd0, 4, 1'b1, 32'h12345678,
               128'h12345678_0000002A_01000001_00040000, 16'h000F, 12'h341, 0);
        do_req("wr_fn0", 16'hBEEF, 8'h11, 8'h00, 1'b1, 3'd3, 3'd2, 0, 1'b1, 32'hFFFFFFFF,
               128'h00000000_26000011_BEEF0000_00040000, 16'h0007, 12'h241, 0);
        do_req("rd_ur", 16'h0203, 8'h7F, 8'h03, 1'b0, 3'd1, 3'd4, 0, 1'b0, 32'h0,
               128'h00000000_4200007F_02030800_00040000, 16'h0007, 12'h241, 0);
        do_req("rd_hold", 16'h1234, 8'h05, 8'h00, 1'b0, 3'd7, 3'd7, 0, 1'b1, 32'hCAFEF00D,
               128'hCAFEF00D_7E000005_12340001_00040000, 16'h000F, 12'h341, 10);
        do_req("wr_ur", 16'hFFFF, 8'hFF, 8'hFF, 1'b1, 3'd0, 3'd0, 0, 1'b0, 32'h0,
               128'h00000000_000000FF_FFFF0800_00040000, 16'h0007, 12'h241, 0);

        // Non-matching traffic and a stray done must leave the block idle.
        cq_tdata  = cq_beat(16'h0001, 8'h01, 8'h02, 3'd0, 3'd0);
        cq_tvalid = 1'b1;
        select    = 2'b00;
        req_type  = 4'b1000;
        done      = 1'b1;
        #1;
        chk("nohit_sel_ready", W'(cq_cfg_tready), W'(0));
        tick();
        chk("nohit_sel_busy", W'(busy), W'(0));
        select   = 2'b01;
        req_type = 4'b0100;
        #1;
        chk("nohit_type_ready", W'(cq_cfg_tready), W'(0));
        tick();
        chk("nohit_type_busy", W'(busy), W'(0));
        cq_tvalid = 1'b0;
        done      = 1'b0;
        tick();

        // Reset while waiting on cfg_mgmt.
        cq_tdata  = cq_beat(16'h0042, 8'h33, 8'h00, 3'd0, 3'd0);
        cq_tvalid = 1'b1;
        req_type  = 4'b1000;
        tick();
        chk("rstw_busy_before", W'(busy), W'(1));
        user_reset = 1'b1;
        tick();
        cq_tvalid = 1'b0;
        chk("rstw_busy", W'(busy), W'(0));
        chk("rstw_tvalid", W'(cc_tvalid), W'(0));
        chk("rstw_ready", W'(cq_cfg_tready), W'(0));
        user_reset = 1'b0;
        tick();
        tick();
        chk("rstw_no_cpl", W'(cc_tvalid), W'(0));

        // Reset while a completion is pending.
        cq_tdata  = cq_beat(16'h0042, 8'h34, 8'h02, 3'd0, 3'd0);
        cq_tvalid = 1'b1;
        tick();
        cq_tvalid = 1'b0;
        chk("rsts_tvalid_before", W'(cc_tvalid), W'(1));
        user_reset = 1'b1;
        tick();
        chk("rsts_tvalid", W'(cc_tvalid), W'(0));
        chk("rsts_tdata", cc_tdata, W'(0));
        chk("rsts_tkeep", W'(cc_tkeep), W'(0));
        chk("rsts_tuser", W'(cc_tuser), W'(0));
        chk("rsts_busy", W'(busy), W'(0));
        user_reset = 1'b0;
        cc_tready  = 1'b1;
        tick();
        cc_tready = 1'b0;
        chk("rsts_no_cpl", W'(cc_tvalid), W'(0));

`ifdef CFG_CPL_TIMEOUT_EN
        do_req("tmo_crs", 16'h0001, 8'h10, 8'h00, 1'b0, 3'd0, 3'd0, 15, 1'b0, 32'h0,
               128'h00000000_00000010_00011000_00040000, 16'h0007, 12'h241, 0);
        do_req("tmo_done_wins", 16'h0001, 8'h10, 8'h00, 1'b0, 3'd0, 3'd0, 15, 1'b1, 32'hA5A5A5A5,
               128'hA5A5A5A5_00000010_00010001_00040000, 16'h000F, 12'h341, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cfg_mgmt_cc_completion_gen.md
Name: cfg_mgmt_cc_completion_gen

Overview:
Downstream partner of the Type 1 CQ-to-cfg_mgmt converter on the DSP CQ/CC interface.
- Tracks each Type 1 config request while cfg_mgmt services it, then pops the CQ beat.
- Builds the single-beat CC completion (CplD for reads, Cpl for writes) and returns it on dsp_s_axis_cc.
- Type 1 requests to a nonzero target function never reach cfg_mgmt. This block answers them directly with a UR completion.

Parameters:
DSP_IF_WIDTH, 512, CQ/CC tdata width
DSP_TKEEP_WIDTH, 16, dword-granular tkeep width
DSP_CQ_TUSER_WIDTH, 231, CQ tuser width (input, unused bits ignored)
DSP_CC_TUSER_WIDTH, 81, CC tuser width
TIMEOUT_CYCLES, 1024, cfg_mgmt wait limit (used only with CFG_CPL_TIMEOUT_EN)

Ports:
user_clk  in  1  clock
user_reset  in  1  synchronous active-high reset
dsp_m_axis_cq_tdata  in  DSP_IF_WIDTH  CQ beat (descriptor [127:0])
dsp_m_axis_cq_tvalid  in  1  CQ valid
dsp_m_axis_cq_tuser  in  DSP_CQ_TUSER_WIDTH  CQ sideband
cq_cfg_tready  out  1  tready contribution for config beats; top muxes it when select==2'b01
select  in  2  CQ routing select; 2'b01 = local config path
req_type  in  4  decoded CQ request type
cfg_mgmt_read_data  in  32  cfg_mgmt read return
cfg_mgmt_read_write_done  in  1  cfg_mgmt access complete
dsp_s_axis_cc_tdata  out  DSP_IF_WIDTH  completion beat
dsp_s_axis_cc_tkeep  out  DSP_TKEEP_WIDTH  dword keep
dsp_s_axis_cc_tlast  out  1  always 1 with tvalid
dsp_s_axis_cc_tuser  out  DSP_CC_TUSER_WIDTH  sop/eop sideband
dsp_s_axis_cc_tvalid  out  1  completion valid
dsp_s_axis_cc_tready  in  1  completion ready
cfg_cpl_busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock user_clk; user_reset is synchronous and active-high.
- Config hit: cfg_hit = cq_tvalid & select==2'b01 & req_type[3:2]==2'b10. fn = cq_tdata[111:104].
- Reset values: state=IDLE; all outputs 0; descriptor/data registers 0.
- FSM states: IDLE, WAIT_DONE, SEND_CPL.
- IDLE:
  - cfg_hit & fn==0: latch descriptor, go to WAIT_DONE. cq_cfg_tready=0.
  - cfg_hit & fn!=0: latch descriptor with status UR (3'b001) and set no-data. cq_cfg_tready=1 this cycle (pop). Go to SEND_CPL.
  - Otherwise: cq_cfg_tready=0.
- Latched descriptor fields:
  - requester ID: tdata[95:80]
  - tag: [103:96]
  - TC: [123:121]
  - attr: [126:124]
  - is_write: req_type[1]
- WAIT_DONE:
  - cq_cfg_tready=0 until cfg_mgmt_read_write_done.
  - On done: cq_cfg_tready=1 combinationally in that cycle; latch read_data if read; status SC (3'b000); go to SEND_CPL.
  - The beat is popped exactly once per request.
- SEND_CPL:
  - cc_tvalid=1; all cc outputs held stable until cc_tready.
  - Handshake cycle: go to IDLE; cc_tvalid drops the next cycle.
  - A new cfg_hit in that same cycle is not accepted. It is evaluated in IDLE.
- CC descriptor (zero elsewhere):
  - lower addr [6:0]=0; byte count [28:16]=4.
  - dword count [42:32]: 1 for read with SC, else 0.
  - status [45:43]; requester ID [63:48]; tag [71:64].
  - completer ID [87:72]=0; completer ID enable [88]=0.
  - TC [91:89]; attr [94:92].
  - Read data in [127:96] only when dword count=1.
- tkeep: 16'h000F with data, 16'h0007 without.
- tuser: [1:0]=2'b01 (sop0); [7:6]=2'b01 (eop0); [11:8]=3 with data, 2 without; all other bits 0.
- Latency: done sampled at cycle N gives cc_tvalid at N+1. UR: hit at N gives cc_tvalid at N+1.
- Spurious cfg_mgmt_read_write_done outside WAIT_DONE is ignored.
- Reset mid-operation: immediate return to IDLE, cc_tvalid=0, pending completion dropped.

Optional Feature:
CFG_CPL_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT_DONE and increments each cycle in WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1 without done: pop the beat (cq_cfg_tready=1), set status CRS (3'b010), no data, go to SEND_CPL.
  - If done and expiry coincide, done wins (SC).
- Undefined: no counter; WAIT_DONE waits indefinitely.

Test Plan:
- Type1 read, fn=0, tag=0x2A, reqID=0x0100, done after 5 cycles, read_data=0x12345678 -> one CC beat: dword count=1, status=0, tag=0x2A, [127:96]=0x12345678, tkeep=0x000F; cq_cfg_tready high exactly one cycle.
- Type1 write, fn=0, done after 1 cycle -> Cpl: dword count=0, byte count=4, tkeep=0x0007, tuser[11:8]=2.
- Type1 read, fn=0x03 -> no wait on cfg_mgmt; completion status=3'b001, no data, cc_tvalid one cycle after hit.
- cc_tready low 10 cycles in SEND_CPL -> tdata/tkeep/tuser stable, no new CQ pop; single transfer on release.
- user_reset asserted in WAIT_DONE and SEND_CPL -> next cycle all outputs 0, state IDLE, no completion.
- With CFG_CPL_TIMEOUT_EN, TIMEOUT_CYCLES=16, done never asserted -> pop and CRS completion after 16 WAIT_DONE cycles; done on cycle 16 -> SC instead.
